// File: rtl/heap_object_writer.sv
// Bump-allocates Lisp heap objects (tag word, then payload) and writes them into word memory.
// Latency: accept edge -> one word written per cycle -> alloc_done one cycle after the last word.
// Backpressure: alloc_ready only in IDLE; mem_busy stalls the current word write indefinitely.
module heap_object_writer #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE      = ADDR_WIDTH'(16'h0100),
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT     = ADDR_WIDTH'(16'hFFFF),
  parameter logic [DATA_WIDTH-1:0] TYPE_NUMBER    = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] TYPE_CONS      = DATA_WIDTH'(2),
  parameter logic [DATA_WIDTH-1:0] TYPE_FUNC_PRIM = DATA_WIDTH'(3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [DATA_WIDTH-1:0] alloc_tag,
  input  logic [DATA_WIDTH-1:0] alloc_field0,
  input  logic [DATA_WIDTH-1:0] alloc_field1,
  output logic                  alloc_done,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_error,
  input  logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] free_ptr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_TAG,
    S_WR_F0,
    S_WR_F1,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] free_ptr_q, free_ptr_d;
  logic [ADDR_WIDTH-1:0] obj_base_q, obj_base_d;
  logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
  logic [DATA_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] f0_q, f0_d;
  logic [DATA_WIDTH-1:0] f1_q, f1_d;
  logic [1:0]            size_q, size_d;

  // Request decode: object size and the last address it would occupy.
  logic                  req_known;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_overflow;

  // Decode the incoming tag and check the object fits below the heap limit.
  // One extra bit keeps a wrap past the top of the address space from looking legal.
  always_comb begin
    req_known = 1'b1;
    req_size  = 2'd2;
    if (alloc_tag == TYPE_CONS) begin
      req_size = 2'd3;
    end else if ((alloc_tag == TYPE_NUMBER) || (alloc_tag == TYPE_FUNC_PRIM)) begin
      req_size = 2'd2;
    end else begin
      req_known = 1'b0;
    end
    req_end      = {1'b0, free_ptr_q} + (ADDR_WIDTH+1)'(req_size) - (ADDR_WIDTH+1)'(1);
    req_overflow = (req_end > {1'b0, HEAP_LIMIT});
  end

  // Next-state logic, memory port drive and handshake outputs.
  always_comb begin
    state_d      = state_q;
    free_ptr_d   = free_ptr_q;
    obj_base_d   = obj_base_q;
    alloc_addr_d = alloc_addr_q;
    tag_d        = tag_q;
    f0_d         = f0_q;
    f1_d         = f1_q;
    size_d       = size_q;
    alloc_ready  = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        alloc_ready = 1'b1;
        if (alloc_valid) begin
          tag_d      = alloc_tag;
          f0_d       = alloc_field0;
          f1_d       = alloc_field1;
          obj_base_d = free_ptr_q;
          size_d     = req_size;
          if (!req_known || req_overflow) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WR_TAG;
          end
        end
      end

      S_WR_TAG: begin
        if (!mem_busy) begin
          mem_we    = 1'b1;
          mem_addr  = obj_base_q;
          mem_wdata = tag_q;
          state_d   = S_WR_F0;
        end
      end

      S_WR_F0: begin
        if (!mem_busy) begin
          mem_we    = 1'b1;
          mem_addr  = obj_base_q + ADDR_WIDTH'(1);
          mem_wdata = f0_q;
          if (size_q == 2'd3) begin
            state_d = S_WR_F1;
          end else begin
            state_d      = S_DONE;
            alloc_addr_d = obj_base_q;
          end
        end
      end

      S_WR_F1: begin
        if (!mem_busy) begin
          mem_we       = 1'b1;
          mem_addr     = obj_base_q + ADDR_WIDTH'(2);
          mem_wdata    = f1_q;
          state_d      = S_DONE;
          alloc_addr_d = obj_base_q;
        end
      end

      S_DONE: begin
        // Commit the allocation only once every word has landed.
        free_ptr_d = obj_base_q + ADDR_WIDTH'(size_q);
        state_d    = S_IDLE;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    alloc_done  = (state_q == S_DONE);
    alloc_error = (state_q == S_ERR);
    alloc_addr  = alloc_addr_q;
    free_ptr    = free_ptr_q;
  end

  // State registers; reset abandons any partially written object.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      free_ptr_q   <= HEAP_BASE;
      obj_base_q   <= '0;
      alloc_addr_q <= '0;
      tag_q        <= '0;
      f0_q         <= '0;
      f1_q         <= '0;
      size_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      free_ptr_q   <= free_ptr_d;
      obj_base_q   <= obj_base_d;
      alloc_addr_q <= alloc_addr_d;
      tag_q        <= tag_d;
      f0_q         <= f0_d;
      f1_q         <= f1_d;
      size_q       <= size_d;
    end
  end

endmodule

// File: tb/tb_heap_object_writer.sv
// Directed bench for heap_object_writer: a default-heap instance and a tiny-heap instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Every expected value below is hand-derived from the object layout and latency rules.
module tb_heap_object_writer;

  logic        clk = 1'b0;
  logic        rst, b_rst;

  logic        a_valid, a_ready, a_done, a_error, a_busy, a_we;
  logic [15:0] a_tag, a_f0, a_f1, a_addr, a_maddr, a_wdata, a_free;

  logic        b_valid, b_ready, b_done, b_error, b_busy, b_we;
  logic [15:0] b_tag, b_f0, b_f1, b_addr, b_maddr, b_wdata, b_free;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  heap_object_writer dut_a (
    .clk(clk), .rst(rst),
    .alloc_valid(a_valid), .alloc_ready(a_ready), .alloc_tag(a_tag),
    .alloc_field0(a_f0), .alloc_field1(a_f1), .alloc_done(a_done),
    .alloc_addr(a_addr), .alloc_error(a_error), .mem_busy(a_busy),
    .mem_addr(a_maddr), .mem_we(a_we), .mem_wdata(a_wdata), .free_ptr(a_free)
  );

  heap_object_writer #(.HEAP_LIMIT(16'h0103)) dut_b (
    .clk(clk), .rst(b_rst),
    .alloc_valid(b_valid), .alloc_ready(b_ready), .alloc_tag(b_tag),
    .alloc_field0(b_f0), .alloc_field1(b_f1), .alloc_done(b_done),
    .alloc_addr(b_addr), .alloc_error(b_error), .mem_busy(b_busy),
    .mem_addr(b_maddr), .mem_we(b_we), .mem_wdata(b_wdata), .free_ptr(b_free)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
    check({tag, "_we"},   a_we,    1);
    check({tag, "_addr"}, a_maddr, addr);
    check({tag, "_data"}, a_wdata, data);
  endtask

  task automatic b_wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
    check({tag, "_we"},   b_we,    1);
    check({tag, "_addr"}, b_maddr, addr);
    check({tag, "_data"}, b_wdata, data);
  endtask

  // Number allocation on the tiny heap with per-word checks.
  task automatic b_num(input string tag, input logic [15:0] f0, input logic [15:0] base);
    b_valid = 1'b1; b_tag = 16'h0001; b_f0 = f0; b_f1 = 16'h0000;
    tick();
    b_valid = 1'b0;
    b_wr({tag, "_w0"}, base, 16'h0001);
    tick();
    b_wr({tag, "_w1"}, 16'(base + 16'd1), f0);
    tick();
    check({tag, "_done"}, b_done, 1);
    check({tag, "_addr"}, b_addr, base);
    tick();
    check({tag, "_free"}, b_free, 16'(base + 16'd2));
    check({tag, "_rdy"},  b_ready, 1);
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b0; a_tag = '0; a_f0 = '0; a_f1 = '0; a_busy = 1'b0;
    b_valid = 1'b0; b_tag = '0; b_f0 = '0; b_f1 = '0; b_busy = 1'b0;
    repeat (2) tick();
    rst = 1'b0; b_rst = 1'b0;

    // Reset state
    check("rst_ready", a_ready, 1);
    check("rst_free",  a_free,  16'h0100);
    check("rst_addr",  a_addr,  16'h0000);
    check("rst_done",  a_done,  0);
    check("rst_err",   a_error, 0);
    check("rst_we",    a_we,    0);
    check("rst_maddr", a_maddr, 16'h0000);
    check("rst_wdata", a_wdata, 16'h0000);

    // Number 42 at 0100
    a_valid = 1'b1; a_tag = 16'h0001; a_f0 = 16'h002A; a_f1 = 16'hBEEF;
    tick();
    a_valid = 1'b0;
    a_wr("num_w0", 16'h0100, 16'h0001);
    check("num_busy_rdy", a_ready, 0);
    tick();
    a_wr("num_w1", 16'h0101, 16'h002A);
    check("num_free_mid", a_free, 16'h0100);
    tick();
    check("num_done",  a_done, 1);
    check("num_addr",  a_addr, 16'h0100);
    check("num_d_we",  a_we,   0);
    tick();
    check("num_done_pulse", a_done, 0);
    check("num_free",  a_free, 16'h0102);
    check("num_hold",  a_addr, 16'h0100);
    check("num_rdy",   a_ready, 1);

    // Cons (0100 . 0000) at 0102, then a number requested during done
    a_valid = 1'b1; a_tag = 16'h0002; a_f0 = 16'h0100; a_f1 = 16'h0000;
    tick();
    a_valid = 1'b0;
    a_wr("cons_w0", 16'h0102, 16'h0002);
    tick();
    a_wr("cons_w1", 16'h0103, 16'h0100);
    tick();
    a_wr("cons_w2", 16'h0104, 16'h0000);
    tick();
    check("cons_done", a_done, 1);
    check("cons_addr", a_addr, 16'h0102);
    check("cons_d_rdy", a_ready, 0);
    a_valid = 1'b1; a_tag = 16'h0001; a_f0 = 16'h0055; a_f1 = 16'h0000;
    tick();
    check("b2b_idle_rdy", a_ready, 1);
    check("b2b_idle_we",  a_we,    0);
    check("b2b_free",     a_free,  16'h0105);
    tick();
    a_valid = 1'b0;
    a_wr("b2b_w0", 16'h0105, 16'h0001);
    tick();
    a_wr("b2b_w1", 16'h0106, 16'h0055);
    tick();
    check("b2b_done", a_done, 1);
    check("b2b_addr", a_addr, 16'h0105);
    tick();
    check("b2b_free2", a_free, 16'h0107);

    // Cons at 0107 with busy held for 5 cycles after the tag write
    a_valid = 1'b1; a_tag = 16'h0002; a_f0 = 16'h1111; a_f1 = 16'h2222;
    tick();
    a_valid = 1'b0;
    a_wr("stl_w0", 16'h0107, 16'h0002);
    tick();
    a_busy = 1'b1;
    #1;
    check("stl_we_c2", a_we, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stl_we_hold", a_we, 0);
      check("stl_nodone", a_done, 0);
    end
    tick();
    a_busy = 1'b0;
    #1;
    a_wr("stl_w1", 16'h0108, 16'h1111);
    tick();
    a_wr("stl_w2", 16'h0109, 16'h2222);
    tick();
    check("stl_done", a_done, 1);
    check("stl_addr", a_addr, 16'h0107);
    tick();
    check("stl_free", a_free, 16'h010A);

    // Unknown tag: sticky error, no writes
    a_valid = 1'b1; a_tag = 16'h0007; a_f0 = 16'h1234; a_f1 = 16'h5678;
    tick();
    check("bad_err",  a_error, 1);
    check("bad_rdy",  a_ready, 0);
    check("bad_we",   a_we,    0);
    check("bad_free", a_free,  16'h010A);
    a_tag = 16'h0001;
    repeat (3) tick();
    check("bad_sticky", a_error, 1);
    check("bad_we2",    a_we,    0);
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bad_clr_err",  a_error, 0);
    check("bad_clr_free", a_free,  16'h0100);

    // Reset after the car write of a cons: no cdr write
    a_valid = 1'b1; a_tag = 16'h0002; a_f0 = 16'hAAAA; a_f1 = 16'hBBBB;
    tick();
    a_valid = 1'b0;
    a_wr("rmid_w0", 16'h0100, 16'h0002);
    tick();
    a_wr("rmid_w1", 16'h0101, 16'hAAAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_we",   a_we,    0);
    check("rmid_free", a_free,  16'h0100);
    check("rmid_rdy",  a_ready, 1);
    check("rmid_err",  a_error, 0);
    check("rmid_addr", a_addr,  16'h0000);
    tick();
    check("rmid_we2",  a_we,    0);

    // Tiny heap (limit 0103): cons at 0102 overflows
    b_num("bn1", 16'h0AAA, 16'h0100);
    b_valid = 1'b1; b_tag = 16'h0002; b_f0 = 16'h0001; b_f1 = 16'h0002;
    tick();
    check("ovf_err",  b_error, 1);
    check("ovf_we",   b_we,    0);
    check("ovf_free", b_free,  16'h0102);
    check("ovf_rdy",  b_ready, 0);
    repeat (2) tick();
    b_valid = 1'b0;
    check("ovf_we2",  b_we,    0);
    check("ovf_rdy2", b_ready, 0);
    check("ovf_err2", b_error, 1);

    // Tiny heap: number at 0102 ends exactly at the limit, the next one overflows
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    b_num("bn2", 16'h0BBB, 16'h0100);
    b_num("bn3", 16'h0CCC, 16'h0102);
    check("lim_err0", b_error, 0);
    b_valid = 1'b1; b_tag = 16'h0003; b_f0 = 16'h0DDD;
    tick();
    b_valid = 1'b0;
    check("lim_err",  b_error, 1);
    check("lim_we",   b_we,    0);
    check("lim_free", b_free,  16'h0104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/heap_object_writer.md
Name: heap_object_writer

Overview:
- Allocates and writes Lisp heap objects into the unified word memory. Objects use the fetch unit's layout: tag word at base, then payload words.
- Sits beside the core's fetch FSM. It drives the memory controller's address, write-enable and write-data port when that port is free, and returns the new object's base address to the evaluator.
- Bump allocator with no garbage collection. Overflowing the heap is a sticky error.

Parameters:
- ADDR_WIDTH, 16, width of memory address and free pointer
- DATA_WIDTH, 16, width of memory words and object fields
- HEAP_BASE, 16'h0100, first word address of the heap; free-pointer reset value
- HEAP_LIMIT, 16'hFFFF, last writable heap address (inclusive)
- TYPE_NUMBER, 1, tag for numbers (2 words: tag, value). Top level overrides with the lisp package value.
- TYPE_CONS, 2, tag for cons cells (3 words: tag, car, cdr)
- TYPE_FUNC_PRIM, 3, tag for primitive functions (2 words: tag, body)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  allocation request
- alloc_ready  out  1  writer can accept a request
- alloc_tag  in  DATA_WIDTH  object tag
- alloc_field0  in  DATA_WIDTH  value, car, or body
- alloc_field1  in  DATA_WIDTH  cdr; ignored for 2-word objects
- alloc_done  out  1  one-cycle pulse: object fully written
- alloc_addr  out  ADDR_WIDTH  base address of the completed object; valid while alloc_done is high and held afterwards
- alloc_error  out  1  sticky: overflow or unknown tag
- mem_busy  in  1  memory port is owned by the fetch unit; writer must not drive writes
- mem_addr  out  ADDR_WIDTH  write address
- mem_we  out  1  write enable
- mem_wdata  out  DATA_WIDTH  write data
- free_ptr  out  ADDR_WIDTH  next free heap address

Behaviour:
- Reset (rst high at a posedge):
  - state IDLE, free_ptr=HEAP_BASE, alloc_addr=0.
  - alloc_done=0, alloc_error=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-object aborts the object. No further writes are issued. Words already written are abandoned and free_ptr returns to HEAP_BASE.
- States: IDLE, WR_TAG, WR_F0, WR_F1, DONE, ERR.
- IDLE:
  - alloc_ready=1.
  - On alloc_valid && alloc_ready, latch tag, field0 and field1, set obj_base=free_ptr, and compute size (CONS=3, NUMBER/FUNC_PRIM=2).
  - Unknown tag -> ERR.
  - Overflow -> ERR, with no memory write. Overflow test: free_ptr+size-1 > HEAP_LIMIT, evaluated at ADDR_WIDTH+1 bits so address wrap cannot pass.
  - Otherwise -> WR_TAG.
- alloc_ready is 0 in every state other than IDLE. Inputs are ignored outside the accept cycle.
- WR_TAG, WR_F0, WR_F1 each write one word:
  - With mem_busy=0: mem_we=1, mem_addr=obj_base+k (k=0,1,2), mem_wdata=tag/field0/field1, then advance.
  - With mem_busy=1: mem_we=0 and the state holds. The write is retried the first cycle mem_busy is low. Busy may stall any word any number of cycles.
  - WR_F0 -> WR_F1 if size==3, else -> DONE.
  - WR_F1 -> DONE.
- mem_addr, mem_we and mem_wdata are combinational from the state registers. mem_we=0 in IDLE, DONE and ERR, and addr/data are 0 there.
- DONE:
  - alloc_done=1 for exactly one cycle and alloc_addr=obj_base.
  - free_ptr<=obj_base+size on the same edge that leaves DONE.
  - -> IDLE. A new request can be accepted the cycle after DONE.
- Latency from the accept edge, no stalls: cons writes at cycles 1,2,3 and done at cycle 4; number/prim writes at cycles 1,2 and done at cycle 3.
- ERR: alloc_error=1, alloc_ready=0, no writes, free_ptr unchanged. Only rst exits ERR.
- An object ending exactly at HEAP_LIMIT is legal. After it, free_ptr=HEAP_LIMIT+1 truncated to ADDR_WIDTH, and the next allocation overflows.
- alloc_valid asserted in the same cycle as alloc_done is not accepted (ready=0). It is accepted in the following IDLE cycle.

Test Plan:
- Number: after reset, request tag=1, field0=16'h002A -> writes [0100]=0001 and [0101]=002A on consecutive cycles; alloc_done 3 cycles after accept with alloc_addr=0100; free_ptr=0102.
- Cons then number back-to-back: cons(car=0100, cdr=0000) -> writes 0102..0104, alloc_addr=0102; the next number lands at 0105; free_ptr=0107; no overlapping writes.
- Stall: hold mem_busy=1 for 5 cycles after the tag write of a cons -> mem_we stays 0 during the stall, the car write occurs the first cycle busy drops, and done arrives 5 cycles late with correct data.
- Overflow: HEAP_LIMIT=16'h0103, heap at 0102, cons request -> alloc_error=1, no mem_we pulse, free_ptr stays 0102, alloc_ready stays 0; a number request at 0102 instead succeeds and ends at 0103.
- Bad tag: tag=16'h0007 -> ERR immediately, no writes, alloc_error sticky until rst.
- Reset mid-cons after the car write -> no cdr write; after reset free_ptr=0100, alloc_ready=1, alloc_error=0.
